// File: rtl/act_stream_unit.sv
// Two-stage streaming activation unit (relu, relu6, hard-swish, hard-sigmoid) on signed fixed-point samples.
// Optional clipped-input counter is compiled in when ACT_CLIP_COUNT_EN is defined.
module act_stream_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic        [1:0]            in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic        [15:0]           clip_count
);

    typedef enum logic [1:0] {
        MODE_RELU     = 2'b00,
        MODE_RELU6    = 2'b01,
        MODE_HSWISH   = 2'b10,
        MODE_HSIGMOID = 2'b11
    } mode_e;

    // t needs room for both the input range and 6*2^FRAC_BITS, plus sign and carry
    localparam int RANGE_W = (DATA_WIDTH > FRAC_BITS + 3) ? DATA_WIDTH : FRAC_BITS + 3;
    localparam int TW      = RANGE_W + 2;
    localparam int PW      = DATA_WIDTH + TW;

    localparam logic signed [TW-1:0] OFFSET  = TW'(3) << FRAC_BITS;
    localparam logic signed [TW-1:0] T_MAX   = TW'(6) << FRAC_BITS;
    localparam logic signed [PW-1:0] T_MAX_P = PW'(T_MAX);
    localparam logic signed [PW-1:0] SIX_P   = PW'(6);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                         s1_valid;
    logic signed [DATA_WIDTH-1:0] s1_x;
    logic signed [TW-1:0]         s1_t;
    mode_e                        s1_mode;
    logic                         s2_ready;

    logic signed [TW-1:0]         x_in_ext;
    logic signed [TW-1:0]         sum_in;
    logic signed [TW-1:0]         t_in;
    logic                         below_in;
    logic                         above_in;

    logic signed [PW-1:0]         x_p;
    logic signed [PW-1:0]         t_p;
    logic signed [PW-1:0]         wide;
    logic signed [DATA_WIDTH-1:0] res;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    always_comb begin
        x_in_ext = TW'(in_data);
        sum_in   = x_in_ext + OFFSET;
        below_in = sum_in[TW-1];
        above_in = sum_in > T_MAX;
        if (below_in)
            t_in = '0;
        else if (above_in)
            t_in = T_MAX;
        else
            t_in = sum_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_t     <= '0;
            s1_mode  <= MODE_RELU;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x    <= in_data;
                s1_t    <= t_in;
                s1_mode <= mode_e'(in_mode);
            end
        end
    end

    // Signed division by a constant truncates toward zero, giving the exact hard-swish result
    always_comb begin
        x_p  = PW'(s1_x);
        t_p  = PW'(s1_t);
        wide = '0;
        case (s1_mode)
            MODE_RELU:     wide = s1_x[DATA_WIDTH-1] ? '0 : x_p;
            MODE_RELU6:    wide = s1_x[DATA_WIDTH-1] ? '0 : ((x_p > T_MAX_P) ? T_MAX_P : x_p);
            MODE_HSWISH:   wide = (x_p * t_p) / T_MAX_P;
            MODE_HSIGMOID: wide = t_p / SIX_P;
            default:       wide = '0;
        endcase
        if (wide > SAT_MAX)
            res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (wide < SAT_MIN)
            res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            res = wide[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid)
                out_data <= res;
        end
    end

`ifdef ACT_CLIP_COUNT_EN
    logic        clip_in;
    logic [15:0] clip_cnt;

    assign clip_in = (mode_e'(in_mode) != MODE_RELU) && (below_in || above_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clip_cnt <= '0;
        else if (in_valid && in_ready && clip_in && (clip_cnt != 16'hFFFF))
            clip_cnt <= clip_cnt + 16'd1;
    end

    assign clip_count = clip_cnt;
`else
    assign clip_count = '0;
`endif

endmodule

// File: doc/act_stream_unit.md
ACT_STREAM_UNIT -- requirements
Module: act_stream_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, sample width (signed fixed-point).
REQ-002 SHALL have parameter FRAC_BITS, default 4, fractional bits (default format Q4.4).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  in  1  input beat valid.
REQ-007 SHALL have port in_ready  out  1  unit accepts the input beat.
REQ-008 SHALL have port in_data  in  DATA_WIDTH  signed input sample x.
REQ-009 SHALL have port in_mode  in  2  function select: 00 relu, 01 relu6, 10 hswish, 11 hsigmoid.
REQ-010 SHALL have port out_valid  out  1  result beat valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the result beat.
REQ-012 SHALL have port out_data  out  DATA_WIDTH  signed result.
REQ-013 SHALL have port clip_count  out  16  number of clipped inputs (see REQ-024).

Function
REQ-014 SHALL transfer a beat on each edge where valid and ready are both high; a beat is never dropped or duplicated.
REQ-015 SHALL be a two-stage pipeline (S1: offset and clamp; S2: multiply, divide, saturate, output register); latency is 2 cycles from input transfer to out_valid with out_ready held high.
REQ-016 SHALL advance each stage when it is empty or its contents move on in the same cycle (bubbles collapse); in_ready = !S1_valid or S1 advancing.
REQ-017 SHALL sustain one beat per cycle with out_ready held high.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute t = clamp(x + 3*2^FRAC_BITS, 0, 6*2^FRAC_BITS) in S1, with at least DATA_WIDTH+1 bits so there is no overflow.
REQ-020 SHALL output relu = max(x, 0); relu6 = clamp(x, 0, 6*2^FRAC_BITS).
REQ-021 SHALL output hswish = x*t / (6*2^FRAC_BITS), truncated toward zero, bit-exact (no approximation error).
REQ-022 SHALL output hsigmoid = floor(t / 6), range 0..2^FRAC_BITS.
REQ-023 SHALL saturate every result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-024 SHALL treat a beat as clipped when mode is relu6, hswish or hsigmoid and x+3 lies outside [0,6] in real terms (clamp active).
REQ-025 SHALL carry mode per beat through the pipeline; a mode change between consecutive beats takes effect with no bubble.

Reset
REQ-026 SHALL, while rst=0, force S1_valid, S2_valid and out_valid to 0, out_data to 0 and clip_count to 0 immediately (asynchronously).
REQ-027 SHALL discard in-flight beats on reset mid-operation; in_ready is 1 on the first edge after rst deasserts.

Configuration
REQ-028 SHALL compile clip_count logic only when macro ACT_CLIP_COUNT_EN is defined.
REQ-029 SHALL, with ACT_CLIP_COUNT_EN, increment clip_count by 1 per clipped beat when it is accepted at the input, saturating at 16'hFFFF.
REQ-030 SHALL, without ACT_CLIP_COUNT_EN, keep port clip_count present and tie it to 0.

Verification
REQ-031 SHALL cover: mode hswish, x=16,-16,0,48,-48 with out_ready=1 -> out_data 10,-5,0,48,0, each 2 cycles after acceptance.
REQ-032 SHALL cover: mode hsigmoid, x=0,127,-128,8 -> 8,16,0,9; mode relu6, x=127 -> 96; mode relu, x=-8 -> 0.
REQ-033 SHALL cover: 5 back-to-back beats with out_ready=0 for 4 cycles -> in_ready=0 after 2 beats are held, out_data stable, all 5 results delivered in order after release.
REQ-034 SHALL cover: rst pulsed low while 2 beats are in flight -> out_valid=0 and clip_count=0 at once, no stale beat emitted afterwards.
REQ-035 SHALL cover: ACT_CLIP_COUNT_EN defined, 3 hsigmoid beats x=127 plus 1 relu beat x=127 -> clip_count=3; undefined -> clip_count=0.
